// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - tick prescaler and mm:ss time-set FSM for the clock counter.
// Optional alarm comparator is compiled in when ALARM_CMP_EN is defined.
module clock_set_ctrl #(
   parameter int CLK_DIV = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [5:0] cur_min,
   input  logic [5:0] cur_sec,
   input  logic [5:0] alarm_min,
   input  logic [5:0] alarm_sec,
   input  logic       alarm_arm,
   output logic       tick_en,
   output logic       load_en,
   output logic [5:0] load_min,
   output logic [5:0] load_sec,
   output logic [1:0] mode,
   output logic       alarm_hit
);

   localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_SET_MIN = 2'd1,
      ST_SET_SEC = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             tick_q, tick_d;
   logic             load_q, load_d;
   logic [5:0]       shadow_min_q, shadow_min_d;
   logic [5:0]       shadow_sec_q, shadow_sec_d;
   logic             btn_mode_q, btn_mode_d;
   logic             btn_inc_q, btn_inc_d;
   logic             mode_press, inc_press;

   function automatic logic [5:0] wrap_inc(input logic [5:0] v);
      return (v == 6'd59) ? 6'd0 : v + 6'd1;
   endfunction

   // Out-of-range counter values are not editable times; start the edit from 0.
   function automatic logic [5:0] clamp59(input logic [5:0] v);
      return (v > 6'd59) ? 6'd0 : v;
   endfunction

   assign mode_press = btn_mode & ~btn_mode_q;
   assign inc_press  = btn_inc & ~btn_inc_q;

   always_comb begin
      state_d      = state_q;
      div_cnt_d    = '0;
      tick_d       = 1'b0;
      load_d       = 1'b0;
      shadow_min_d = shadow_min_q;
      shadow_sec_d = shadow_sec_q;
      btn_mode_d   = btn_mode;
      btn_inc_d    = btn_inc;

      if (state_q == ST_RUN) begin
         if (div_cnt_q == DIV_LAST) begin
            tick_d = 1'b1;
         end else begin
            div_cnt_d = div_cnt_q + 1'b1;
         end
      end

      // Mode press has priority over a coincident increment press.
      case (state_q)
         ST_RUN: begin
            if (mode_press) begin
               shadow_min_d = clamp59(cur_min);
               shadow_sec_d = clamp59(cur_sec);
               state_d      = ST_SET_MIN;
            end
         end
         ST_SET_MIN: begin
            if (mode_press) begin
               state_d = ST_SET_SEC;
            end else if (inc_press) begin
               shadow_min_d = wrap_inc(shadow_min_q);
            end
         end
         ST_SET_SEC: begin
            if (mode_press) begin
               state_d   = ST_RUN;
               load_d    = 1'b1;
               div_cnt_d = '0;
            end else if (inc_press) begin
               shadow_sec_d = wrap_inc(shadow_sec_q);
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_RUN;
         div_cnt_q    <= '0;
         tick_q       <= 1'b0;
         load_q       <= 1'b0;
         shadow_min_q <= 6'd0;
         shadow_sec_q <= 6'd0;
         btn_mode_q   <= 1'b0;
         btn_inc_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         div_cnt_q    <= div_cnt_d;
         tick_q       <= tick_d;
         load_q       <= load_d;
         shadow_min_q <= shadow_min_d;
         shadow_sec_q <= shadow_sec_d;
         btn_mode_q   <= btn_mode_d;
         btn_inc_q    <= btn_inc_d;
      end
   end

   assign tick_en  = tick_q;
   assign load_en  = load_q;
   assign load_min = shadow_min_q;
   assign load_sec = shadow_sec_q;
   assign mode     = state_q;

`ifdef ALARM_CMP_EN
   logic tick_dly_q, tick_dly_d;
   logic alarm_hit_q, alarm_hit_d;

   // Delayed tick lines up with the counter value that the tick produced.
   always_comb begin
      tick_dly_d  = tick_q;
      alarm_hit_d = tick_dly_q && (state_q == ST_RUN) && alarm_arm &&
                    (cur_min == alarm_min) && (cur_sec == alarm_sec);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_dly_q  <= 1'b0;
         alarm_hit_q <= 1'b0;
      end else begin
         tick_dly_q  <= tick_dly_d;
         alarm_hit_q <= alarm_hit_d;
      end
   end

   assign alarm_hit = alarm_hit_q;
`else
   logic unused_alarm;
   assign unused_alarm = ^{alarm_min, alarm_sec, alarm_arm};
   assign alarm_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - directed bench for clock_set_ctrl with a cycle model.
module tb_clock_set_ctrl;

   localparam int CLK_DIV = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic       alarm_arm = 1'b0;
   logic [5:0] cur_min = 6'd0;
   logic [5:0] cur_sec = 6'd0;
   logic [5:0] alarm_min = 6'd0;
   logic [5:0] alarm_sec = 6'd0;
   logic       tick_en, load_en, alarm_hit;
   logic [5:0] load_min, load_sec;
   logic [1:0] mode;

   int checks = 0;
   int errors = 0;
   int tick_in_set = 0;
   int alarm_cnt = 0;

   clock_set_ctrl #(.CLK_DIV(CLK_DIV)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_mode  (btn_mode),
      .btn_inc   (btn_inc),
      .cur_min   (cur_min),
      .cur_sec   (cur_sec),
      .alarm_min (alarm_min),
      .alarm_sec (alarm_sec),
      .alarm_arm (alarm_arm),
      .tick_en   (tick_en),
      .load_en   (load_en),
      .load_min  (load_min),
      .load_sec  (load_sec),
      .mode      (mode),
      .alarm_hit (alarm_hit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Reference model: mode as 0/1/2, elapsed RUN cycles, shadow time as integers.
   int m_mode = 0, m_run = 0, m_smin = 0, m_ssec = 0;
   bit m_tick = 0, m_load = 0, m_alarm = 0, m_tick_prev = 0, m_pm = 0, m_pi = 0;

   task automatic m_reset();
      m_mode = 0; m_run = 0; m_smin = 0; m_ssec = 0;
      m_tick = 0; m_load = 0; m_alarm = 0; m_tick_prev = 0; m_pm = 0; m_pi = 0;
   endtask

   task automatic m_step();
      bit pm, pi, n_tick, n_load, n_alarm;
      int n_mode, n_run, n_smin, n_ssec;
      pm = btn_mode && !m_pm;
      pi = btn_inc && !m_pi;
      n_mode = m_mode; n_smin = m_smin; n_ssec = m_ssec; n_load = 0;
      n_tick = (m_mode == 0) && (((m_run + 1) % CLK_DIV) == 0);
      n_run  = (m_mode == 0) ? m_run + 1 : 0;
      n_alarm = 0;
`ifdef ALARM_CMP_EN
      n_alarm = m_tick_prev && (m_mode == 0) && alarm_arm &&
                (cur_min == alarm_min) && (cur_sec == alarm_sec);
`endif
      if (pm) begin
         case (m_mode)
            0: begin
               n_mode = 1;
               n_smin = (cur_min > 59) ? 0 : int'(cur_min);
               n_ssec = (cur_sec > 59) ? 0 : int'(cur_sec);
            end
            1: n_mode = 2;
            default: begin n_mode = 0; n_load = 1; n_run = 0; end
         endcase
      end else if (pi && m_mode == 1) begin
         n_smin = (m_smin + 1) % 60;
      end else if (pi && m_mode == 2) begin
         n_ssec = (m_ssec + 1) % 60;
      end
      m_tick_prev = m_tick;
      m_mode = n_mode; m_run = n_run; m_smin = n_smin; m_ssec = n_ssec;
      m_tick = n_tick; m_load = n_load; m_alarm = n_alarm;
      m_pm = btn_mode; m_pi = btn_inc;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) m_reset();
      else     m_step();
   end

   always @(negedge clk) begin
      chk("tick_en", tick_en, m_tick);
      chk("load_en", load_en, m_load);
      chk("load_min", load_min, m_smin);
      chk("load_sec", load_sec, m_ssec);
      chk("mode", mode, m_mode);
      chk("alarm_hit", alarm_hit, m_alarm);
      if (!rst && tick_en && mode != 2'd0) tick_in_set++;
      if (alarm_hit) alarm_cnt++;
   end

   task automatic press(input bit m, input bit i);
      btn_mode = m; btn_inc = i;
      @(negedge clk);
      btn_mode = 0; btn_inc = 0;
      @(negedge clk);
   endtask

   task automatic wait_tick(input string name);
      bit found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (tick_en) found = 1;
      end
      chk(name, found, 1);
   endtask

   initial begin
      logic [11:0] pat;
      bit ld_seen;
      int hit1, hit2, hit3, exp_hit, a0;
`ifdef ALARM_CMP_EN
      exp_hit = 1;
`else
      exp_hit = 0;
`endif
      repeat (2) @(negedge clk);
      chk("reset_mode", mode, 0);
      chk("reset_load_en", load_en, 0);
      rst = 0;

      // Free-running ticks at cycles 4, 8, 12
      pat = '0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         pat[k-1] = tick_en;
      end
      chk("t1_tick_pattern", int'(pat), 12'h888);
      chk("t1_mode", mode, 0);

      // Edit 12:34 -> 15:00 and load it
      cur_min = 6'd12; cur_sec = 6'd34;
      press(1, 0);
      chk("t2_mode_set_min", mode, 1);
      chk("t2_cap_min", load_min, 12);
      chk("t2_cap_sec", load_sec, 34);
      repeat (3) press(0, 1);
      chk("t2_min_15", load_min, 15);
      press(1, 0);
      chk("t2_mode_set_sec", mode, 2);
      repeat (26) press(0, 1);
      chk("t2_sec_wrap", load_sec, 0);
      btn_mode = 1;
      @(negedge clk);
      chk("t2_load_pulse", load_en, 1);
      chk("t2_mode_run", mode, 0);
      chk("t2_load_min", load_min, 15);
      btn_mode = 0;
      pat = '0;
      ld_seen = 0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         pat[k-1] = tick_en;
         ld_seen |= load_en;
      end
      chk("t2_tick_after_load", int'(pat[4:0]), 5'b01000);
      chk("t2_single_load", ld_seen, 0);
      chk("t2_no_tick_in_set", tick_in_set, 0);

      // Held increment counts once; 59 wraps to 0
      cur_min = 6'd59; cur_sec = 6'd59;
      press(1, 0);
      chk("t3_cap_min", load_min, 59);
      btn_inc = 1;
      repeat (10) @(negedge clk);
      btn_inc = 0;
      @(negedge clk);
      chk("t3_held_inc", load_min, 0);

      // Simultaneous presses: mode wins
      press(1, 1);
      chk("t4_mode", mode, 2);
      chk("t4_min_kept", load_min, 0);

      // Out-of-range capture clamps to 0
      press(1, 0);
      cur_min = 6'd61; cur_sec = 6'd63;
      press(1, 0);
      chk("t4_clamp_min", load_min, 0);
      chk("t4_clamp_sec", load_sec, 0);
      press(1, 0);
      press(1, 0);

      // Async reset mid-edit of 07:42
      cur_min = 6'd7; cur_sec = 6'd42;
      press(1, 0);
      press(1, 0);
      chk("t5_mode", mode, 2);
      chk("t5_shadow", int'({load_min, load_sec}), int'({6'd7, 6'd42}));
      #2 rst = 1;
      #1;
      chk("t5_rst_mode", mode, 0);
      chk("t5_rst_shadow", int'({load_min, load_sec}), 0);
      chk("t5_rst_pulses", int'({tick_en, load_en}), 0);
      @(negedge clk);
      rst = 0;
      pat = '0;
      ld_seen = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         pat[k-1] = tick_en;
         ld_seen |= load_en;
      end
      chk("t5_tick_pattern", int'(pat), 12'h888);
      chk("t5_no_load", ld_seen, 0);

      // Alarm 00:03 armed, counter steps 00:02 -> 00:03 on a tick
      a0 = alarm_cnt;
      alarm_min = 6'd0; alarm_sec = 6'd3; alarm_arm = 1;
      cur_min = 6'd0; cur_sec = 6'd2;
      wait_tick("t6_wait_tick_armed");
      @(negedge clk);
      cur_sec = 6'd3;
      hit1 = alarm_hit;
      @(negedge clk);
      hit2 = alarm_hit;
      @(negedge clk);
      hit3 = alarm_hit;
      alarm_arm = 0;
      cur_sec = 6'd2;
      chk("t6_hit_t1", hit1, 0);
      chk("t6_hit_t2", hit2, exp_hit);
      chk("t6_hit_t3", hit3, 0);

      // Disarmed: same step must not fire
      wait_tick("t6_wait_tick_disarmed");
      @(negedge clk);
      cur_sec = 6'd3;
      repeat (4) @(negedge clk);
      chk("t6_alarm_total", alarm_cnt - a0, exp_hit);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
